matrix_multiplier_array: RTL and testbench

Parametrised N×N output-stationary systolic matrix multiplier for the tensor-core datapath, successor to the fixed 2×2, 8-bit core. It accepts one column of A and one row of B per beat over a valid/ready stream for a run-time depth K. It computes C = A·B in signed or unsigned mode and streams C out one row per beat over a second valid/ready interface. Input skewing, flush and result drain are all internal, so the host only streams operands and collects rows.

---
 rtl/matrix_multiplier_array.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_matrix_multiplier_array.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_multiplier_array.sv
// N x N output-stationary systolic matrix multiplier with valid/ready operand and result streams.
// Define MATMUL_SATURATE_EN to clamp every accumulate to the ACC_W range and raise the sticky sat flag.
module matrix_multiplier_array #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 4 * DATA_W,
    parameter int K_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   signed_mode,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [N*DATA_W-1:0]    a_data,
    input  logic [N*DATA_W-1:0]    b_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N*ACC_W-1:0]     res_data,
    output logic [$clog2(N)-1:0]   res_row,
    output logic                   busy,
    output logic                   sat
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);
    localparam int PW = 2 * DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             signed_q, signed_d;
    logic [K_W-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [RW-1:0]    row_q, row_d;
    logic             accept;
    logic             clear;
    logic             mac_en;

    logic [ACC_W-1:0]  acc_q [N][N];
    logic [ACC_W-1:0]  acc_d [N][N];
    logic [DATA_W-1:0] a_pe_q [N][N-1];
    logic [DATA_W-1:0] a_pe_d [N][N-1];
    logic [DATA_W-1:0] b_pe_q [N-1][N];
    logic [DATA_W-1:0] b_pe_d [N-1][N];
    logic [DATA_W-1:0] a_in [N][N];
    logic [DATA_W-1:0] b_in [N][N];
    logic [DATA_W-1:0] a_tap [N];
    logic [DATA_W-1:0] b_tap [N];

    // Operand extended by one bit so a single signed multiplier covers both modes.
    function automatic logic signed [PW-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic              sgn);
        logic signed [DATA_W:0] sa;
        logic signed [DATA_W:0] sb;
        sa = signed'({sgn & a[DATA_W-1], a});
        sb = signed'({sgn & b[DATA_W-1], b});
        return PW'(sa) * PW'(sb);
    endfunction

`ifdef MATMUL_SATURATE_EN
    localparam int SW = ACC_W + 2;

    // Returns {clamped, value}; two guard bits make overflow visible in either mode.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]     acc,
                                               input logic signed [PW-1:0] p,
                                               input logic                 sgn);
        logic signed [SW-1:0] sum;
        sum = signed'({{2{sgn & acc[ACC_W-1]}}, acc}) + SW'(p);
        if (sgn) begin
            if (sum[SW-1:ACC_W-1] != '0 && sum[SW-1:ACC_W-1] != '1) begin
                return sum[SW-1] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
            return {1'b0, sum[ACC_W-1:0]};
        end
        if (sum[SW-1]) begin
            return {1'b1, {ACC_W{1'b0}}};
        end
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    logic sat_q, sat_d;
    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        signed_d  = signed_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        row_d     = row_q;
        accept    = 1'b0;
        clear     = 1'b0;
        a_ready   = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d      = k_len;
                    signed_d = signed_mode;
                    cnt_d    = '0;
                    flush_d  = '0;
                    row_d    = '0;
                    clear    = 1'b1;
                    state_d  = (k_len == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == k_q - 1'b1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == FW'(2 * N - 2)) begin
                    flush_d = '0;
                    state_d = DRAIN;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            DRAIN: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign mac_en = (state_q == LOAD) || (state_q == FLUSH);

    // Row/column g is delayed g+1 cycles so operand k meets at PE(i,j) on the same edge.
    for (genvar g = 0; g < N; g++) begin : g_skew
        localparam int unsigned D = g;
        logic [DATA_W-1:0] a_sk_q [D+1];
        logic [DATA_W-1:0] a_sk_d [D+1];
        logic [DATA_W-1:0] b_sk_q [D+1];
        logic [DATA_W-1:0] b_sk_d [D+1];

        always_comb begin
            a_sk_d[0] = accept ? a_data[g*DATA_W +: DATA_W] : '0;
            b_sk_d[0] = accept ? b_data[g*DATA_W +: DATA_W] : '0;
            for (int unsigned m = 1; m <= D; m++) begin
                a_sk_d[m] = a_sk_q[m-1];
                b_sk_d[m] = b_sk_q[m-1];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned m = 0; m <= D; m++) begin
                    a_sk_q[m] <= '0;
                    b_sk_q[m] <= '0;
                end
            end else begin
                a_sk_q <= a_sk_d;
                b_sk_q <= b_sk_d;
            end
        end

        assign a_tap[g] = a_sk_q[D];
        assign b_tap[g] = b_sk_q[D];
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            a_in[i][0] = a_tap[i];
            for (int unsigned j = 1; j < N; j++) begin
                a_in[i][j] = a_pe_q[i][j-1];
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            b_in[0][j] = b_tap[j];
            for (int unsigned i = 1; i < N; i++) begin
                b_in[i][j] = b_pe_q[i-1][j];
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N - 1; j++) begin
                a_pe_d[i][j] = a_in[i][j];
            end
        end
        for (int unsigned i = 0; i < N - 1; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                b_pe_d[i][j] = b_in[i][j];
            end
        end
    end

    always_comb begin
        logic signed [PW-1:0] prod;
        logic                 clip;
        acc_d = acc_q;
        prod  = '0;
        clip  = 1'b0;
`ifdef MATMUL_SATURATE_EN
        sat_d = sat_q;
`endif
        if (clear) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    acc_d[i][j] = '0;
                end
            end
`ifdef MATMUL_SATURATE_EN
            sat_d = 1'b0;
`endif
        end else if (mac_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    prod = mul_ext(a_in[i][j], b_in[i][j], signed_q);
`ifdef MATMUL_SATURATE_EN
                    {clip, acc_d[i][j]} = sat_add(acc_q[i][j], prod, signed_q);
                    if (clip) begin
                        sat_d = 1'b1;
                    end
`else
                    acc_d[i][j] = acc_q[i][j] + ACC_W'(prod);
`endif
                end
            end
        end
    end

    always_comb begin
        res_data = '0;
        for (int unsigned j = 0; j < N; j++) begin
            res_data[j*ACC_W +: ACC_W] = acc_q[row_q][j];
        end
    end

    assign res_row = row_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            flush_q  <= '0;
            row_q    <= '0;
`ifdef MATMUL_SATURATE_EN
            sat_q    <= 1'b0;
`endif
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N - 1; j++) begin
                    a_pe_q[i][j] <= '0;
                end
            end
            for (int unsigned i = 0; i < N - 1; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    b_pe_q[i][j] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            row_q    <= row_d;
`ifdef MATMUL_SATURATE_EN
            sat_q    <= sat_d;
`endif
            acc_q    <= acc_d;
            a_pe_q   <= a_pe_d;
            b_pe_q   <= b_pe_d;
        end
    end

endmodule

// File: tb/tb_matrix_multiplier_array.sv
// Directed self-checking bench: a 4x4/32-bit array and a 2x2/16-bit array driven with hand-computed jobs.
module tb_matrix_multiplier_array;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, signed_mode = 1'b0, a_valid = 1'b0, res_ready = 1'b0;
    logic [7:0]   k_len = '0;
    logic [31:0]  a_data = '0, b_data = '0;
    logic         a_ready, res_valid, busy, sat;
    logic [127:0] res_data;
    logic [1:0]   res_row;

    logic         m2_start = 1'b0, m2_signed = 1'b0, m2_a_valid = 1'b0, m2_res_ready = 1'b0;
    logic [7:0]   m2_k_len = '0;
    logic [15:0]  m2_a_data = '0, m2_b_data = '0;
    logic         m2_a_ready, m2_res_valid, m2_busy, m2_sat;
    logic [31:0]  m2_res_data;
    logic [0:0]   m2_res_row;

    int checks = 0;
    int failures = 0;

    logic [31:0]  a_beats [256];
    logic [31:0]  b_beats [256];
    logic [127:0] rows4 [4];
    logic [15:0]  a2 [4];
    logic [15:0]  b2 [4];
    logic [31:0]  rows2 [2];

    matrix_multiplier_array #(.N(4), .DATA_W(8), .ACC_W(32), .K_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
        .busy(busy), .sat(sat)
    );

    matrix_multiplier_array #(.N(2), .DATA_W(8), .ACC_W(16), .K_W(8)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(m2_start), .k_len(m2_k_len), .signed_mode(m2_signed),
        .a_valid(m2_a_valid), .a_ready(m2_a_ready), .a_data(m2_a_data), .b_data(m2_b_data),
        .res_valid(m2_res_valid), .res_ready(m2_res_ready), .res_data(m2_res_data), .res_row(m2_res_row),
        .busy(m2_busy), .sat(m2_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [7:0] k, input logic sgn);
        start = 1'b1; k_len = k; signed_mode = sgn;
        tick();
        start = 1'b0;
    endtask

    task automatic feed4(input int k, input int gap);
        int waited;
        for (int b = 0; b < k; b++) begin
            waited = 0;
            a_valid = 1'b1; a_data = a_beats[b]; b_data = b_beats[b];
            while (!a_ready && waited < 16) begin tick(); waited++; end
            checks++;
            if (a_ready !== 1'b1) begin
                failures++;
                $display("FAIL feed4_a_ready beat=%0d got=%b exp=1", b, a_ready);
            end
            tick();
            a_valid = 1'b0; a_data = '0; b_data = '0;
            if (b < k - 1) repeat (gap) tick();
        end
    endtask

    task automatic collect4(output int lat);
        int w;
        lat = 0;
        for (int r = 0; r < 4; r++) rows4[r] = 'x;
        res_ready = 1'b1;
        while (!res_valid && lat < 64) begin tick(); lat++; end
        for (int r = 0; r < 4; r++) begin
            w = 0;
            while (!res_valid && w < 16) begin tick(); w++; end
            if (res_valid) rows4[res_row] = res_data;
            tick();
        end
    endtask

    task automatic start2(input logic [7:0] k, input logic sgn);
        m2_start = 1'b1; m2_k_len = k; m2_signed = sgn;
        tick();
        m2_start = 1'b0;
    endtask

    task automatic feed2(input int k, input int gap);
        int waited;
        for (int b = 0; b < k; b++) begin
            waited = 0;
            m2_a_valid = 1'b1; m2_a_data = a2[b]; m2_b_data = b2[b];
            while (!m2_a_ready && waited < 16) begin tick(); waited++; end
            checks++;
            if (m2_a_ready !== 1'b1) begin
                failures++;
                $display("FAIL feed2_a_ready beat=%0d got=%b exp=1", b, m2_a_ready);
            end
            tick();
            m2_a_valid = 1'b0; m2_a_data = '0; m2_b_data = '0;
            if (b < k - 1) repeat (gap) tick();
        end
    endtask

    task automatic collect2(output int lat);
        int w;
        lat = 0;
        for (int r = 0; r < 2; r++) rows2[r] = 'x;
        m2_res_ready = 1'b1;
        while (!m2_res_valid && lat < 64) begin tick(); lat++; end
        for (int r = 0; r < 2; r++) begin
            w = 0;
            while (!m2_res_valid && w < 16) begin tick(); w++; end
            if (m2_res_valid) rows2[m2_res_row] = m2_res_data;
            tick();
        end
    endtask

    task automatic load_identity();
        for (int k = 0; k < 4; k++) begin
            a_beats[k] = 32'd1 << (8 * k);
            b_beats[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        end
    endtask

    task automatic check_identity_rows(input string tag);
        logic [127:0] exp;
        for (int r = 0; r < 4; r++) begin
            exp = {32'(4*r+4), 32'(4*r+3), 32'(4*r+2), 32'(4*r+1)};
            checks++;
            if (rows4[r] !== exp) begin
                failures++;
                $display("FAIL %s_row%0d got=%h exp=%h", tag, r, rows4[r], exp);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({a_ready, res_valid, busy, sat, res_row} !== 6'b0 || res_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b row=%0d data=%h exp=all zero",
                     a_ready, res_valid, busy, sat, res_row, res_data);
        end
        checks++;
        if ({m2_a_ready, m2_res_valid, m2_busy, m2_sat, m2_res_row} !== 5'b0 || m2_res_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs_n2 got=%b%b%b%b data=%h exp=all zero",
                     m2_a_ready, m2_res_valid, m2_busy, m2_sat, m2_res_data);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b a_ready=%b exp=0 0", busy, a_ready);
        end
    endtask

    task automatic test_identity();
        int lat;
        load_identity();
        start4(8'd4, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL identity_busy got=%b exp=1", busy);
        end
        feed4(4, 0);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL identity_early_valid got=%b exp=0", res_valid);
        end
        collect4(lat);
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL identity_latency got=%0d exp=7", lat);
        end
        check_identity_rows("identity");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL identity_idle busy=%b exp=0", busy);
        end
    endtask

    task automatic test_extremes();
        logic [7:0]  v;
        logic        s;
        logic [31:0] exp;
        int          lat;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin v = 8'h80; s = 1'b1; exp = 32'd4177920;  end
                1: begin v = 8'h80; s = 1'b0; exp = 32'd4177920;  end
                2: begin v = 8'hFF; s = 1'b0; exp = 32'd16581375; end
                default: begin v = 8'hFF; s = 1'b1; exp = 32'd255; end
            endcase
            for (int b = 0; b < 255; b++) begin
                a_beats[b] = {4{v}};
                b_beats[b] = {4{v}};
            end
            start4(8'd255, s);
            feed4(255, 0);
            collect4(lat);
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (rows4[r] !== {4{exp}}) begin
                    failures++;
                    $display("FAIL extremes_case%0d_row%0d got=%h exp=%h", c, r, rows4[r], {4{exp}});
                end
            end
        end
    endtask

    task automatic test_acc16();
        int          lat;
        logic [15:0] exp;
        logic        exp_sat;
`ifdef MATMUL_SATURATE_EN
        exp = 16'h7FFF; exp_sat = 1'b1;
`else
        exp = 16'h8000; exp_sat = 1'b0;
`endif
        a2[0] = 16'h8080; a2[1] = 16'h8080;
        b2[0] = 16'h8080; b2[1] = 16'h8080;
        start2(8'd2, 1'b1);
        feed2(2, 0);
        collect2(lat);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL acc16_latency got=%0d exp=3", lat);
        end
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (rows2[r] !== {2{exp}}) begin
                failures++;
                $display("FAIL acc16_row%0d got=%h exp=%h", r, rows2[r], {2{exp}});
            end
        end
        checks++;
        if (m2_sat !== exp_sat) begin
            failures++;
            $display("FAIL acc16_sat got=%b exp=%b", m2_sat, exp_sat);
        end
    endtask

    task automatic test_n2_signed();
        int lat;
        a2[0] = 16'h0301; a2[1] = 16'h0402;
        b2[0] = 16'h0605; b2[1] = 16'h0807;
        start2(8'd2, 1'b1);
        checks++;
        if (m2_sat !== 1'b0) begin
            failures++;
            $display("FAIL n2_sat_cleared got=%b exp=0", m2_sat);
        end
        feed2(2, 1);
        collect2(lat);
        checks++;
        if (rows2[0] !== {16'd22, 16'd19}) begin
            failures++;
            $display("FAIL n2_row0 got=%h exp=%h", rows2[0], {16'd22, 16'd19});
        end
        checks++;
        if (rows2[1] !== {16'd50, 16'd43}) begin
            failures++;
            $display("FAIL n2_row1 got=%h exp=%h", rows2[1], {16'd50, 16'd43});
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp [4];
        int           w;
        exp[0] = {32'd40,  32'd30,  32'd20, 32'd10};
        exp[1] = {32'd80,  32'd60,  32'd40, 32'd20};
        exp[2] = {32'd120, 32'd90,  32'd60, 32'd30};
        exp[3] = {32'd160, 32'd120, 32'd80, 32'd40};
        a_beats[0] = 32'h04030201;
        b_beats[0] = 32'h281E140A;
        start4(8'd1, 1'b0);
        feed4(1, 0);
        res_ready = 1'b1;
        w = 0;
        while (!res_valid && w < 32) begin tick(); w++; end
        checks++;
        if (res_valid !== 1'b1 || res_row !== 2'd0 || res_data !== exp[0]) begin
            failures++;
            $display("FAIL bp_row0 valid=%b row=%0d got=%h exp=%h", res_valid, res_row, res_data, exp[0]);
        end
        tick();
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin start = 1'b1; k_len = 8'd0; end
            tick();
            start = 1'b0;
            checks++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_row !== 2'd1 || res_data !== exp[1]) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b busy=%b row=%0d got=%h exp=%h",
                         c, res_valid, busy, res_row, res_data, exp[1]);
            end
        end
        res_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            checks++;
            if (res_row !== 2'(r) || res_data !== exp[r]) begin
                failures++;
                $display("FAIL bp_row%0d row=%0d got=%h exp=%h", r, res_row, res_data, exp[r]);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done busy=%b valid=%b exp=0 0", busy, res_valid);
        end
    endtask

    task automatic test_k0();
        int lat;
        start4(8'd0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL k0_busy got=%b exp=1", busy);
        end
        collect4(lat);
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL k0_latency got=%0d exp=7", lat);
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (rows4[r] !== '0) begin
                failures++;
                $display("FAIL k0_row%0d got=%h exp=0", r, rows4[r]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int lat;
        load_identity();
        start4(8'd4, 1'b0);
        for (int b = 0; b < 2; b++) begin
            a_valid = 1'b1; a_data = a_beats[b]; b_data = b_beats[b];
            tick();
        end
        a_data = a_beats[2]; b_data = b_beats[2];
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, res_valid, busy, sat, res_row} !== 6'b0 || res_data !== '0) begin
            failures++;
            $display("FAIL midload_reset a_ready=%b valid=%b busy=%b sat=%b row=%0d data=%h exp=all zero",
                     a_ready, res_valid, busy, sat, res_row, res_data);
        end
        a_valid = 1'b0; a_data = '0; b_data = '0;
        tick();
        reset_n = 1'b1;
        tick();
        start4(8'd4, 1'b0);
        feed4(4, 0);
        collect4(lat);
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL after_reset_latency got=%0d exp=7", lat);
        end
        check_identity_rows("after_reset");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_extremes();
        test_acc16();
        test_n2_signed();
        test_backpressure();
        test_k0();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
